spm_seq: RTL
============

SPM_SEQ -- requirements
Module: spm_seq

Interface
REQ-001 The block SHALL have parameter SIZE, default 32, giving the operand width and matching the width of the attached serial-parallel multiplier.
REQ-002 Port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-003 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 Port in_valid, input, 1 bit: operand pair valid.
REQ-005 Port in_ready, output, 1 bit: block can accept an operand pair.
REQ-006 Port in_x, input, SIZE bits: multiplicand, two's complement.
REQ-007 Port in_y, input, SIZE bits: multiplier, unsigned.
REQ-008 Port spm_rst, output, 1 bit: registered clear to the multiplier.
REQ-009 Port spm_x, output, SIZE bits: parallel multiplicand to the multiplier.
REQ-010 Port spm_y, output, 1 bit: serial multiplier bit, LSB first.
REQ-011 Port spm_p, input, 1 bit: serial product bit from the multiplier, LSB first.
REQ-012 Port out_valid, output, 1 bit: product valid.
REQ-013 Port out_ready, input, 1 bit: consumer accepts the product.
REQ-014 Port out_p, output, 2*SIZE bits: product, two's complement.
REQ-015 Port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, CLR, RUN and DONE.
REQ-017 IDLE: in_ready SHALL be 1; on in_valid&in_ready the block SHALL latch in_x and in_y and go to CLR.
REQ-018 CLR SHALL last exactly 1 cycle, then go to RUN with the cycle counter c=0.
REQ-019 RUN SHALL last exactly 2*SIZE+1 cycles, c=0..2*SIZE; after c=2*SIZE it SHALL go to DONE.
REQ-020 In RUN, spm_y SHALL be y_latched[c] for c<SIZE and 0 for c>=SIZE (zero extension).
REQ-021 In RUN, for c=1..2*SIZE, spm_p SHALL be shifted into the product register MSB-first-in (P <= {spm_p, P[2*SIZE-1:1]}), so that product bit k is the value sampled at c=k+1; spm_p at c=0 SHALL be ignored.
REQ-022 spm_x SHALL equal x_latched, held stable from CLR through the end of RUN.
REQ-023 spm_rst SHALL be a flop output that is 1 in IDLE and CLR and 0 in RUN and DONE.
REQ-024 DONE: out_valid SHALL be 1 and out_p SHALL hold the full product, stable until out_valid&out_ready.
REQ-025 On out_valid&out_ready the block SHALL return to IDLE; out_p SHALL keep its value and out_valid SHALL drop in the next cycle.
REQ-026 in_ready SHALL be 0 in CLR, RUN and DONE; there is no overlap of operations, so a new accept happens no earlier than the cycle after the DONE handshake.
REQ-027 Latency from the accept edge to out_valid=1 SHALL be 2*SIZE+2 cycles when out_ready is held high.
REQ-028 out_p SHALL equal signed(in_x) times unsigned(in_y), exact in 2*SIZE bits with no overflow.
REQ-029 The cycle counter SHALL be clog2(2*SIZE+1) bits wide and SHALL not wrap within RUN.
REQ-030 in_valid while busy SHALL be ignored, with no latch and no state change.

Reset
REQ-031 Asserting rst at any time, including mid-RUN, SHALL force state=IDLE, in_ready=1, out_valid=0, out_p=0, spm_rst=1, spm_y=0, spm_x=0 and counter=0.
REQ-032 After rst deasserts, the first accept SHALL produce a correct product, with no residue from the aborted operation.

Structure
REQ-033 Package spm_pkg SHALL hold the FSM state encoding and the counter-width function/constant.
REQ-034 The block SHALL contain no sub-module; the spm multiplier SHALL be instantiated by the parent, wired spm_x->x, spm_y->y, spm_p<-p, spm_rst->rst.

Verification
REQ-035 SIZE=8, x=50, y=206, out_ready=1: out_p=16'h283C (10300), and out_valid rises exactly 18 cycles after the accept.
REQ-036 SIZE=8, x=0xFD (-3), y=5: out_p=16'hFFF1 (-15); x=0x80, y=0xFF: out_p=16'h8080 (-32640).
REQ-037 out_ready held 0 for 5 cycles in DONE, with in_valid=1 and different operands: out_p stable, in_ready=0, no new operation starts; the next operation starts only after release.
REQ-038 rst pulsed at RUN c=7, then x=7, y=9: outputs at reset values during rst, then out_p=16'h003F.
REQ-039 Back-to-back: in_valid held high with x=1,y=1 then x=-1,y=255: products 16'h0001 then 16'hFF01, and spm_rst=1 in each CLR cycle.

Source files
------------

// File: rtl/spm_pkg.sv
// Shared definitions for the serial-parallel multiplier sequencer:
// FSM state encoding and the run-counter width helper.
package spm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } spm_state_t;

    // Run counter must hold 0..2*size without wrapping.
    function automatic int cnt_width(input int size);
        return $clog2(2 * size + 1);
    endfunction

endpackage

// File: rtl/spm_seq.sv
// Sequencer for an external serial-parallel multiplier: latches one operand pair,
// streams the multiplier LSB first, collects the serial product and hands it out.
module spm_seq
    import spm_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SIZE-1:0]     in_x,
    input  logic [SIZE-1:0]     in_y,
    output logic                spm_rst,
    output logic [SIZE-1:0]     spm_x,
    output logic                spm_y,
    input  logic                spm_p,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*SIZE-1:0]   out_p,
    output logic                busy
);

    localparam int              CW       = cnt_width(SIZE);
    localparam logic [CW-1:0]   CNT_LAST = CW'(2 * SIZE);

    spm_state_t         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [SIZE-1:0]    x_q, x_d;
    logic [SIZE-1:0]    y_q, y_d;
    logic [2*SIZE-1:0]  p_q, p_d;
    logic               spm_rst_q, spm_rst_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            p_q       <= '0;
            spm_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            p_q       <= p_d;
            spm_rst_q <= spm_rst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        p_d     = p_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = in_x;
                    y_d     = in_y;
                    state_d = CLR;
                end
            end
            CLR: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                // y drains one bit per cycle; once empty it supplies the zero extension.
                y_d = {1'b0, y_q[SIZE-1:1]};
                // The multiplier output is registered, so the bit seen at c=0 is stale.
                if (cnt_q != '0) begin
                    p_d = {spm_p, p_q[2*SIZE-1:1]};
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        spm_rst_d = (state_d == IDLE) || (state_d == CLR);
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign out_p     = p_q;
    assign spm_x     = x_q;
    assign spm_y     = (state_q == RUN) ? y_q[0] : 1'b0;
    assign spm_rst   = spm_rst_q;

endmodule
